// File: rtl/music_pkg.sv
// Shared music constants: tone half-period table, rest threshold and the
// sequencer FSM state encoding.
package music_pkg;

  localparam int unsigned NUM_TONES = 8;
  localparam int unsigned REST_CODE = 8;

  // Half-periods in 100 MHz clock cycles, do..do'.
  localparam logic [31:0] HALF_PERIOD_TABLE [NUM_TONES] = '{
    32'd305810, 32'd272479, 32'd242718, 32'd229042,
    32'd204081, 32'd181818, 32'd161969, 32'd152905
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  function automatic logic [31:0] tone_half_period(input logic [2:0] code,
                                                   input int unsigned shift);
    logic [31:0] hp;
    hp = HALF_PERIOD_TABLE[code] >> shift;
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator. Dropping enable clears the counter and phase, so
// the caller lowers it for one cycle to restart the wave at phase 0.
module tone_gen #(
  parameter int AUDIO_W = 12
) (
  input  logic               clock,
  input  logic               RST,
  input  logic [31:0]        half_period,
  input  logic               enable,
  input  logic [AUDIO_W-1:0] volume,
  output logic [AUDIO_W-1:0] sample
);

  logic [31:0]        cnt_q, cnt_n;
  logic               phase_q, phase_n;
  logic [AUDIO_W-1:0] sample_n;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_n   = '0;
    phase_n = 1'b0;
    if (enable) begin
      if (cnt_q + 32'd1 >= half_period) begin
        cnt_n   = '0;
        phase_n = ~phase_q;
      end else begin
        cnt_n   = cnt_q + 32'd1;
        phase_n = phase_q;
      end
    end
    sample_n = phase_n ? volume : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sample  <= '0;
    end else begin
      cnt_q   <= cnt_n;
      phase_q <= phase_n;
      sample  <= sample_n;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: walks a flattened pattern of tone codes at a programmable
// tempo and drives a square-wave tone generator.
module note_sequencer
  import music_pkg::*;
#(
  parameter int NUM_STEPS = 32,
  parameter int CODE_W    = 4,
  parameter int AUDIO_W   = 12,
  parameter int HP_SHIFT  = 0
) (
  input  logic                         clock,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [NUM_STEPS*CODE_W-1:0]  pattern,
  input  logic [31:0]                  tempo_ticks,
  input  logic [AUDIO_W-1:0]           volume,
  output logic [AUDIO_W-1:0]           audio_out,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic [NUM_STEPS-1:0]         step_onehot,
  output logic                         playing,
  output logic                         done
);

  localparam int IDX_W = $clog2(NUM_STEPS);

  state_t            state_q, state_n;
  logic [IDX_W-1:0]  idx_n, idx_load;
  logic [CODE_W-1:0] code_q, code_n;
  logic [CODE_W-1:0] step_codes [NUM_STEPS];
  logic [31:0]       tick_q, tick_n, last_tick_q, last_tick_n;
  logic [31:0]       half_period;
  logic              done_n, load, is_rest, tone_en;

  always_comb begin
    for (int s = 0; s < NUM_STEPS; s++) begin
      step_codes[s] = pattern[(NUM_STEPS-1-s)*CODE_W +: CODE_W];
    end
  end

  assign is_rest     = 32'(code_q) >= REST_CODE;
  assign half_period = tone_half_period(3'(code_q), HP_SHIFT);

  // Stop beats start; start in PLAY restarts at step 0.
  always_comb begin
    state_n     = state_q;
    idx_n       = step_idx;
    code_n      = code_q;
    last_tick_n = last_tick_q;
    tick_n      = '0;
    done_n      = 1'b0;
    load        = 1'b0;
    idx_load    = '0;
    if (stop) begin
      state_n = ST_IDLE;
    end else if (start) begin
      state_n = ST_PLAY;
      load    = 1'b1;
    end else if (state_q == ST_PLAY) begin
      if (tick_q == last_tick_q) begin
        if (step_idx == IDX_W'(NUM_STEPS-1)) begin
          if (loop_en) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          load     = 1'b1;
          idx_load = step_idx + IDX_W'(1);
        end
      end else begin
        tick_n = tick_q + 32'd1;
      end
    end
    if (load) begin
      idx_n       = idx_load;
      code_n      = step_codes[idx_load];
      last_tick_n = (tempo_ticks == 32'd0) ? 32'd0 : tempo_ticks - 32'd1;
    end
  end

  // The tone runs only while the same tone step continues into the next cycle.
  assign tone_en = (state_n == ST_PLAY) && !load && !is_rest;

  always_ff @(posedge clock) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      step_idx    <= '0;
      code_q      <= '0;
      tick_q      <= '0;
      last_tick_q <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      step_idx    <= idx_n;
      code_q      <= code_n;
      tick_q      <= tick_n;
      last_tick_q <= last_tick_n;
      done        <= done_n;
    end
  end

  assign playing = (state_q == ST_PLAY);

  always_comb begin
    for (int s = 0; s < NUM_STEPS; s++) begin
      step_onehot[NUM_STEPS-1-s] = playing && (step_idx == IDX_W'(s));
    end
  end

  tone_gen #(.AUDIO_W(AUDIO_W)) u_tone_gen (
    .clock       (clock),
    .RST         (RST),
    .half_period (half_period),
    .enable      (tone_en),
    .volume      (volume),
    .sample      (audio_out)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized
// stimulus, all compared against a step/cycle-count reference model.
module tb_note_sequencer;

  localparam int NUM_STEPS = 4;
  localparam int CODE_W    = 4;
  localparam int AUDIO_W   = 12;
  localparam int HP_SHIFT  = 16;

  logic                  clock = 1'b0;
  logic                  RST, start, stop, loop_en;
  logic [15:0]           pattern;
  logic [31:0]           tempo_ticks;
  logic [AUDIO_W-1:0]    volume;
  logic [AUDIO_W-1:0]    audio_out;
  logic [1:0]            step_idx;
  logic [NUM_STEPS-1:0]  step_onehot;
  logic                  playing, done;

  note_sequencer #(
    .NUM_STEPS(NUM_STEPS), .CODE_W(CODE_W), .AUDIO_W(AUDIO_W), .HP_SHIFT(HP_SHIFT)
  ) dut (
    .clock(clock), .RST(RST), .start(start), .stop(stop), .loop_en(loop_en),
    .pattern(pattern), .tempo_ticks(tempo_ticks), .volume(volume),
    .audio_out(audio_out), .step_idx(step_idx), .step_onehot(step_onehot),
    .playing(playing), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
  endtask

  // Reference model: "which step, how many cycles into it, how long it lasts".
  int unsigned ref_table [8] = '{305810, 272479, 242718, 229042, 204081, 181818, 161969, 152905};
  bit m_play, m_done;
  int m_idx, m_k, m_len, m_code;
  logic [AUDIO_W-1:0] m_vol;
  int done_cnt, wrap_cnt, prev_idx;
  bit prev_play;

  function automatic int code_at(input logic [15:0] p, input int s);
    return int'((p >> ((NUM_STEPS-1-s)*CODE_W)) & 16'hF);
  endfunction

  function automatic int ref_hp(input int code);
    int unsigned hp;
    hp = ref_table[code] >> HP_SHIFT;
    return (hp == 0) ? 1 : int'(hp);
  endfunction

  task automatic enter_step(input int s);
    m_idx  = s;
    m_k    = 0;
    m_len  = (tempo_ticks == 0) ? 1 : int'(tempo_ticks);
    m_code = code_at(pattern, s);
  endtask

  task automatic model_step();
    m_vol  = volume;
    m_done = 1'b0;
    if (RST) begin
      m_play = 1'b0; m_idx = 0; m_k = 0; m_len = 1; m_code = 0;
    end else if (stop) begin
      m_play = 1'b0;
    end else if (start) begin
      m_play = 1'b1;
      enter_step(0);
    end else if (m_play) begin
      if (m_k + 1 >= m_len) begin
        if (m_idx == NUM_STEPS-1 && !loop_en) begin
          m_play = 1'b0;
          m_done = 1'b1;
        end else begin
          enter_step((m_idx + 1) % NUM_STEPS);
        end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic cycle();
    logic [AUDIO_W-1:0] exp_audio;
    logic [NUM_STEPS-1:0] exp_onehot;
    @(posedge clock);
    model_step();
    #1;
    exp_audio  = '0;
    exp_onehot = '0;
    if (m_play) begin
      exp_onehot = NUM_STEPS'(1) << (NUM_STEPS-1-m_idx);
      if (m_code < 8 && ((m_k / ref_hp(m_code)) % 2) == 1) exp_audio = m_vol;
    end
    check("playing", 64'(playing), 64'(m_play));
    check("step_idx", 64'(step_idx), 64'(m_idx));
    check("onehot", 64'(step_onehot), 64'(exp_onehot));
    check("done", 64'(done), 64'(m_done));
    check("audio", 64'(audio_out), 64'(exp_audio));
    if (done) done_cnt++;
    if (prev_play && playing && prev_idx == NUM_STEPS-1 && step_idx == 0) wrap_cnt++;
    prev_play = playing;
    prev_idx  = int'(step_idx);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    pattern = 16'h0F7F; tempo_ticks = 32'd10; volume = 12'hFFF;
    m_play = 0; m_done = 0; m_idx = 0; m_k = 0; m_len = 1; m_code = 0; m_vol = '0;
    done_cnt = 0; wrap_cnt = 0; prev_idx = 0; prev_play = 0;

    // Reset state
    run(2);
    RST = 1'b0;
    run(2);
    check("rst_audio", 64'(audio_out), 64'd0);
    check("rst_idx", 64'(step_idx), 64'd0);

    // Single non-looping run over 0x0F7F at tempo 10
    done_cnt = 0;
    pulse_start();
    check("start_latency", 64'(playing), 64'd1);
    run(45);
    check("run_done_pulses", 64'(done_cnt), 64'd1);
    check("run_end_idle", 64'(playing), 64'd0);
    check("idle_idx_held", 64'(step_idx), 64'd3);

    // Looping for 50 cycles
    loop_en = 1'b1; done_cnt = 0; wrap_cnt = 0;
    pulse_start();
    run(50);
    check("loop_no_done", 64'(done_cnt), 64'd0);
    check("loop_wrapped", 64'(wrap_cnt), 64'd1);

    // Simultaneous start + stop while playing
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("ss_playing", 64'(playing), 64'd0);
    check("ss_audio", 64'(audio_out), 64'd0);
    check("ss_onehot", 64'(step_onehot), 64'd0);
    run(3);

    // tempo 0, reset at cycle 15 of a run
    tempo_ticks = 32'd0; done_cnt = 0;
    pulse_start();
    run(14);
    RST = 1'b1; cycle(); RST = 1'b0;
    check("rst_mid_playing", 64'(playing), 64'd0);
    check("rst_mid_idx", 64'(step_idx), 64'd0);
    check("rst_mid_onehot", 64'(step_onehot), 64'd0);
    check("rst_mid_audio", 64'(audio_out), 64'd0);
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    run(3);

    // Randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, 79) == 0);
      RST     = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) loop_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 29) == 0) pattern = 16'($urandom);
      if ($urandom_range(0, 29) == 0) tempo_ticks = $urandom_range(0, 14);
      if ($urandom_range(0, 199) == 0) volume = 12'($urandom);
      cycle();
    end
    start = 1'b0; stop = 1'b0; RST = 1'b0;
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 32, meaning number of pattern steps (2..64).
REQ-002 SHALL have parameter CODE_W, default 4, meaning tone-code width per step.
REQ-003 SHALL have parameter AUDIO_W, default 12, meaning audio sample width.
REQ-004 SHALL have parameter HP_SHIFT, default 0, meaning right-shift applied to tone half-period counts (simulation speed-up).
REQ-005 SHALL have port clock, input, 1, meaning system clock (100 MHz); the block uses one clock only.
REQ-006 SHALL have port RST, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning single-cycle play request.
REQ-008 SHALL have port stop, input, 1, meaning single-cycle stop request.
REQ-009 SHALL have port loop_en, input, 1, meaning wrap to step 0 after the last step instead of halting.
REQ-010 SHALL have port pattern, input, NUM_STEPS*CODE_W, meaning flattened tone codes, step 0 in the most-significant CODE_W bits.
REQ-011 SHALL have port tempo_ticks, input, 32, meaning clock cycles per step.
REQ-012 SHALL have port volume, input, AUDIO_W, meaning high level of the square wave.
REQ-013 SHALL have port audio_out, output, AUDIO_W, meaning sample to the DAC driver.
REQ-014 SHALL have port step_idx, output, clog2(NUM_STEPS), meaning current step index.
REQ-015 SHALL have port step_onehot, output, NUM_STEPS, meaning one-hot current step for LEDs (bit NUM_STEPS-1 = step 0).
REQ-016 SHALL have port playing, output, 1, meaning the FSM is in PLAY.
REQ-017 SHALL have port done, output, 1, meaning single-cycle pulse when a non-looping run completes.

Function
REQ-018 FSM SHALL have states IDLE and PLAY.
- IDLE->PLAY on start (registered, 1-cycle latency).
- PLAY->IDLE on stop, or at the end of the last step when loop_en=0.
REQ-019 Simultaneous start and stop SHALL resolve as stop; start while in PLAY SHALL restart at step 0.
REQ-020 On entering PLAY or at any step boundary, step_idx, the tone code, the tick counter (0) and the tone phase (0) SHALL all update in the same cycle; the tone code is sampled from pattern at that cycle, so pattern edits take effect at the next boundary.
REQ-021 A step SHALL last max(tempo_ticks,1) cycles; tempo_ticks is sampled at each boundary.
REQ-022 After step NUM_STEPS-1: loop_en=1 -> step 0, with no gap cycle; loop_en=0 -> IDLE, with done=1 for exactly one cycle.
REQ-023 Tone codes 0..7 SHALL map to half-periods 305810, 272479, 242718, 229042, 204081, 181818, 161969, 152905 (do..do'), each >>HP_SHIFT and clamped to a minimum of 1.
REQ-024 Codes 8..max SHALL be rests.
REQ-025 Tone generator behaviour:
- In a tone step, a counter runs 0..half_period-1 and toggles phase on wrap.
- audio_out = phase ? volume : 0, registered.
- In a rest step, or in IDLE, audio_out = 0 and phase is held at 0.
REQ-026 step_onehot SHALL equal the decode of step_idx in PLAY and all-zero in IDLE; step_idx SHALL hold its last value in IDLE.

Reset
REQ-027 RST SHALL force IDLE, step_idx=0, step_onehot=0, audio_out=0, playing=0, done=0, and all counters and the phase to 0, on the next clock edge, overriding start/stop.
REQ-028 RST asserted mid-PLAY SHALL abort the run without asserting done.

Structure
REQ-029 The tone half-period table, REST code threshold (8) and FSM state encoding SHALL live in shared package music_pkg.
REQ-030 Tone generation SHALL be one sub-module, tone_gen (inputs: clock, RST, half_period, enable, volume; output: sample).

Verification
Bench parameters: NUM_STEPS=4, HP_SHIFT=16, tempo_ticks=10.
REQ-031 Reset then start pulse: playing=1 one cycle later, step_idx 0->1->2->3 every 10 cycles, done pulse after step 3, playing=0.
REQ-032 pattern=0x0F7F, loop_en=0: step 0 square wave with half-period 4 cycles at volume 0xFFF; step 1 audio_out=0; step 2 half-period 2.
REQ-033 loop_en=1 for 50 cycles: step_idx wraps 3->0 with no gap cycle, done never asserted.
REQ-034 Simultaneous start+stop in PLAY -> IDLE next cycle, audio_out=0, step_onehot=0.
REQ-035 tempo_ticks=0 -> every step lasts 1 cycle; RST at cycle 15 of a run -> all outputs 0 next cycle, no done pulse.
